// File: rtl/dm_port_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// dm_port_arbiter_if: core/aux request, response and data-memory bus
// Revision: 1.0
// ------------------------------------------------------------------
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int WEN_W  = 8
);
  logic              i_core_valid;
  logic [ADDR_W-1:0] i_core_addr;
  logic [WEN_W-1:0]  i_core_wen;
  logic [DATA_W-1:0] i_core_wdata;
  logic              o_core_ready;
  logic              o_core_rsp_valid;
  logic              o_core_stall;
  logic              i_aux_valid;
  logic              i_aux_lock;
  logic [ADDR_W-1:0] i_aux_addr;
  logic [WEN_W-1:0]  i_aux_wen;
  logic [DATA_W-1:0] i_aux_wdata;
  logic              o_aux_ready;
  logic              o_aux_rsp_valid;
  logic [DATA_W-1:0] o_rsp_rdata;
  logic [ADDR_W-1:0] o_dm_addr;
  logic [WEN_W-1:0]  o_dm_wen;
  logic [DATA_W-1:0] o_dm_wdata;
  logic [DATA_W-1:0] i_dm_rdata;

  modport slave (
    input  i_core_valid, i_core_addr, i_core_wen, i_core_wdata,
    input  i_aux_valid, i_aux_lock, i_aux_addr, i_aux_wen, i_aux_wdata,
    input  i_dm_rdata,
    output o_core_ready, o_core_rsp_valid, o_core_stall,
    output o_aux_ready, o_aux_rsp_valid, o_rsp_rdata,
    output o_dm_addr, o_dm_wen, o_dm_wdata
  );

  modport master (
    output i_core_valid, i_core_addr, i_core_wen, i_core_wdata,
    output i_aux_valid, i_aux_lock, i_aux_addr, i_aux_wen, i_aux_wdata,
    output i_dm_rdata,
    input  o_core_ready, o_core_rsp_valid, o_core_stall,
    input  o_aux_ready, o_aux_rsp_valid, o_rsp_rdata,
    input  o_dm_addr, o_dm_wen, o_dm_wdata
  );
endinterface
`default_nettype wire

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// dm_port_arbiter: core-priority data-memory arbiter with aux anti-starvation and lock bursts
// Revision: 1.0
// ------------------------------------------------------------------
module dm_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int WEN_W        = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  dm_port_arbiter_if.slave  bus
);
  localparam int c_starve_w = $clog2(STARVE_LIMIT) + 1;
  localparam int c_burst_w  = $clog2(MAX_BURST) + 1;

  localparam logic [1:0] c_core_pri  = 2'd0;
  localparam logic [1:0] c_aux_force = 2'd1;
  localparam logic [1:0] c_aux_lock  = 2'd2;

  localparam logic [c_starve_w-1:0] c_starve_one  = c_starve_w'(1);
  localparam logic [c_starve_w-1:0] c_starve_last = c_starve_w'(STARVE_LIMIT - 1);
  localparam logic [c_burst_w-1:0]  c_burst_one   = c_burst_w'(1);
  localparam logic [c_burst_w-1:0]  c_burst_max   = c_burst_w'(MAX_BURST);
  localparam logic                  c_lock_ok     = (MAX_BURST > 1);

  logic [1:0]            r_state, w_state_nxt;
  logic [c_starve_w-1:0] r_starve_cnt, w_starve_nxt;
  logic [c_burst_w-1:0]  r_burst_cnt, w_burst_nxt, w_burst_inc;
  logic                  r_idle, w_idle_nxt;
  logic                  r_rsp_pending, r_rsp_owner;
  logic                  w_grant_core, w_grant_aux, w_lock_exit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_core_pri;
      r_starve_cnt <= '0;
      r_burst_cnt  <= '0;
      r_idle       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_burst_cnt  <= w_burst_nxt;
      r_idle       <= w_idle_nxt;
    end
  end

  always_comb begin
    w_grant_core = 1'b0;
    w_grant_aux  = 1'b0;
    case (r_state)
      c_core_pri: begin
        w_grant_core = bus.i_core_valid;
        w_grant_aux  = bus.i_aux_valid & ~bus.i_core_valid;
      end
      c_aux_force: begin
        w_grant_aux  = bus.i_aux_valid;
        w_grant_core = bus.i_core_valid & ~bus.i_aux_valid;
      end
      c_aux_lock: w_grant_aux = bus.i_aux_valid;
      default: ;
    endcase
  end

  assign w_burst_inc = r_burst_cnt + c_burst_one;
  // r_idle marks one lock-held cycle without a request; a second one abandons the lock
  assign w_lock_exit = ~bus.i_aux_lock
                     | (w_grant_aux & (w_burst_inc == c_burst_max))
                     | (~bus.i_aux_valid & r_idle);

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    w_burst_nxt  = r_burst_cnt;
    w_idle_nxt   = r_idle;
    case (r_state)
      c_core_pri: begin
        if (bus.i_aux_valid & ~w_grant_aux) begin
          w_starve_nxt = r_starve_cnt + c_starve_one;
          if (r_starve_cnt == c_starve_last) w_state_nxt = c_aux_force;
        end else begin
          w_starve_nxt = '0;
        end
        if (w_grant_aux & bus.i_aux_lock & c_lock_ok) begin
          w_state_nxt = c_aux_lock;
          w_burst_nxt = c_burst_one;
          w_idle_nxt  = 1'b0;
        end
      end
      c_aux_force: begin
        w_starve_nxt = '0;
        w_idle_nxt   = 1'b0;
        if (w_grant_aux & bus.i_aux_lock & c_lock_ok) begin
          w_state_nxt = c_aux_lock;
          w_burst_nxt = c_burst_one;
        end else begin
          w_state_nxt = c_core_pri;
        end
      end
      c_aux_lock: begin
        if (w_grant_aux) begin
          w_burst_nxt = w_burst_inc;
          w_idle_nxt  = 1'b0;
        end else begin
          w_idle_nxt  = 1'b1;
        end
        if (w_lock_exit) begin
          w_state_nxt  = c_core_pri;
          w_burst_nxt  = '0;
          w_starve_nxt = '0;
          w_idle_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = c_core_pri;
        w_starve_nxt = '0;
        w_burst_nxt  = '0;
        w_idle_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_pending <= 1'b0;
      r_rsp_owner   <= 1'b0;
    end else begin
      r_rsp_pending <= (w_grant_core & ~|bus.i_core_wen) | (w_grant_aux & ~|bus.i_aux_wen);
      r_rsp_owner   <= w_grant_aux;
    end
  end

  assign bus.o_core_ready     = w_grant_core;
  assign bus.o_aux_ready      = w_grant_aux;
  assign bus.o_core_stall     = bus.i_core_valid & ~w_grant_core;
  assign bus.o_dm_addr        = w_grant_core ? bus.i_core_addr  : (w_grant_aux ? bus.i_aux_addr  : '0);
  assign bus.o_dm_wen         = w_grant_core ? bus.i_core_wen   : (w_grant_aux ? bus.i_aux_wen   : '0);
  assign bus.o_dm_wdata       = w_grant_core ? bus.i_core_wdata : (w_grant_aux ? bus.i_aux_wdata : '0);
  assign bus.o_core_rsp_valid = r_rsp_pending & ~r_rsp_owner;
  assign bus.o_aux_rsp_valid  = r_rsp_pending & r_rsp_owner;
  assign bus.o_rsp_rdata      = r_rsp_pending ? bus.i_dm_rdata : '0;
endmodule
`default_nettype wire
